rr_priority_arbiter: RTL

//   Shares one resource among N requesters. The winner is chosen by a priority

---
 rtl/rr_priority_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rr_priority_arbiter.sv
// Arbiter granting one shared resource to one of N requesters, using either
// fixed (highest index) or round-robin priority, with a hold timeout and turnaround.
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // One-hot style encoding so the two unused codes are easy to spot and recover from.
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]  win;
    logic              rel_done;
    logic              rel_drop;
    logic              rel_hold;

    function automatic logic [IDX_W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] sel;
        w = '0;
        for (int i = 0; i < N; i++) begin
            sel = IDX_W'(i);
            if (r[sel]) w = sel;
        end
        return w;
    endfunction

    // Walk candidates from lowest to highest priority so the last hit wins:
    // last itself is weakest, last-1 (wrapping) is strongest.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] sel;
        int               idx;
        w = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) - k + N) % N;
            sel = IDX_W'(idx);
            if (r[sel]) w = sel;
        end
        return w;
    endfunction

    assign win      = rr_mode ? rr_pick(req, last_q) : fixed_pick(req);
    assign rel_done = done;
    assign rel_drop = !req[gnt_idx_q];
    assign rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << win;
                    gnt_idx_d   = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_W'(1);
                    last_d      = win;
                end
            end

            GRANT: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = rel_hold && !rel_done && !rel_drop;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                last_d      = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_q      <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
